lcd_sync_gen: RTL and testbench

- Parametrised LCD timing generator; successor to the fixed-timing LCD sync block.
- Produces the pixel clock (NCLK), panel reset (GREST), HD/VD syncs, DEN and the active-area row/column coordinates that the pixel-data path consumes.
- New relative to the fixed block:
  - all H/V timings, divider, sync polarities and coordinate widths are parameters;
  - EN freeze input;
  - delayed GREST release;
  - SOF/SOL strobes and a frame counter.
- Sits between the system clock domain and the panel connector, driving the frame-buffer reader.

---
 rtl/lcd_timing_pkg.sv | 37 +++
 rtl/lcd_sync_gen_if.sv | 30 +++
 rtl/lcd_tick_div.sv | 45 ++++
 rtl/lcd_sync_gen.sv | 186 ++++++++++++++++++
 tb/tb_lcd_sync_gen.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_pkg.sv
// Default 800x480 panel timing and helpers shared by the LCD sync generator.
// Totals, counter widths and active-window edges are derived here.
package lcd_timing_pkg;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 210;
    localparam int DEF_H_SYNC   = 30;
    localparam int DEF_H_BP     = 16;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 22;
    localparam int DEF_V_SYNC   = 13;
    localparam int DEF_V_BP     = 10;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_FILA_W   = 10;
    localparam int DEF_COL_W    = 11;
    localparam int DEF_FRM_W    = 8;

    localparam int DEF_H_START = DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_H_STOP  = DEF_H_START + DEF_H_ACTIVE;
    localparam int DEF_V_START = DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_V_STOP  = DEF_V_START + DEF_V_ACTIVE;

    function automatic int calc_total(input int sync_len, input int bp_len,
                                      input int act_len, input int fp_len);
        return sync_len + bp_len + act_len + fp_len;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int win_start(input int sync_len, input int bp_len);
        return sync_len + bp_len;
    endfunction

endpackage

// File: rtl/lcd_sync_gen_if.sv
// Panel-side bundle of the LCD sync generator: freeze input plus all timing outputs.
interface lcd_sync_gen_if
    import lcd_timing_pkg::*;
#(
    parameter int FILA_W = DEF_FILA_W,
    parameter int COL_W  = DEF_COL_W,
    parameter int FRM_W  = DEF_FRM_W
);
    logic              EN;
    logic              NCLK;
    logic              GREST;
    logic              HD;
    logic              VD;
    logic              DEN;
    logic [FILA_W-1:0] FILA;
    logic [COL_W-1:0]  COLUMNA;
    logic              SOF;
    logic              SOL;
    logic [FRM_W-1:0]  FRAME_CNT;

    modport master (
        input  EN,
        output NCLK, GREST, HD, VD, DEN, FILA, COLUMNA, SOF, SOL, FRAME_CNT
    );

    modport slave (
        output EN,
        input  NCLK, GREST, HD, VD, DEN, FILA, COLUMNA, SOF, SOL, FRAME_CNT
    );
endinterface

// File: rtl/lcd_tick_div.sv
// Pixel-period divider: counts CLK cycles within a pixel, drives NCLK and the advance tick.
module lcd_tick_div
    import lcd_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic run,
    output logic tick,
    output logic nclk
);
    localparam int DW = cnt_w(CLK_DIV);
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] d_q, d_d;
    logic          nclk_q, nclk_d;
    logic          adv;

    always_comb begin
        adv    = en && run;
        d_d    = d_q;
        nclk_d = nclk_q;
        if (adv) begin
            d_d    = (d_q == D_LAST) ? '0 : d_q + DW'(1);
            nclk_d = (d_d >= D_HALF);
        end
    end

    // tick marks the edge on which the divider wraps and h must advance
    assign tick = adv && (d_q == D_LAST);
    assign nclk = nclk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= '0;
            nclk_q <= 1'b0;
        end else begin
            d_q    <= d_d;
            nclk_q <= nclk_d;
        end
    end
endmodule

// File: rtl/lcd_sync_gen.sv
// Parametrised LCD timing generator: GREST sequencing, H/V counters and registered
// sync/DEN/coordinate decode for the pixel at (h,v).
module lcd_sync_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int GREST_DLY = 0,
    parameter int FILA_W    = DEF_FILA_W,
    parameter int COL_W     = DEF_COL_W,
    parameter int FRM_W     = DEF_FRM_W
) (
    input logic            CLK,
    input logic            RST,
    lcd_sync_gen_if.master bus
);
    localparam int H_TOT = calc_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOT = calc_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int HW    = cnt_w(H_TOT);
    localparam int VW    = cnt_w(V_TOT);
    localparam int GW    = cnt_w(GREST_DLY + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GREST_DLY);

    localparam logic [31:0] H_SYNC_C = 32'(H_SYNC);
    localparam logic [31:0] V_SYNC_C = 32'(V_SYNC);
    localparam logic [31:0] H_START  = 32'(win_start(H_SYNC, H_BP));
    localparam logic [31:0] V_START  = 32'(win_start(V_SYNC, V_BP));
    localparam logic [31:0] H_STOP   = 32'(win_start(H_SYNC, H_BP) + H_ACTIVE);
    localparam logic [31:0] V_STOP   = 32'(win_start(V_SYNC, V_BP) + V_ACTIVE);

    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
        $error("lcd_sync_gen: CLK_DIV must be even and >= 2");
    end
    if (FILA_W < 1 || COL_W < 1 || FRM_W < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_zero
        $error("lcd_sync_gen: widths and active sizes must be non-zero");
    end
    if ((64'd1 << FILA_W) < 64'(V_ACTIVE) || (64'd1 << COL_W) < 64'(H_ACTIVE)) begin : g_bad_width
        $error("lcd_sync_gen: FILA_W/COL_W too narrow for the active area");
    end

    logic              grest_q, grest_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic              started_q, started_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [FRM_W-1:0]  frm_q, frm_d;
    logic              sof_q, sof_d;
    logic              sol_q, sol_d;
    logic              hd_q, hd_d;
    logic              vd_q, vd_d;
    logic              den_q, den_d;
    logic [FILA_W-1:0] fila_q, fila_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              load;
    logic              tick;
    logic              nclk;
    logic [31:0]       h_ext, v_ext;
    logic              h_in, v_in;

    lcd_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk  (CLK),
        .rst  (RST),
        .en   (bus.EN),
        .run  (started_q),
        .tick (tick),
        .nclk (nclk)
    );

    always_comb begin
        gcnt_d    = gcnt_q;
        grest_d   = grest_q;
        started_d = started_q;
        h_d       = h_q;
        v_d       = v_q;
        frm_d     = frm_q;
        load      = 1'b0;
        sof_d     = 1'b0;
        sol_d     = 1'b0;
        // GREST delay runs regardless of EN
        if (!grest_q) begin
            if (gcnt_q == G_LAST) grest_d = 1'b1;
            else                  gcnt_d  = gcnt_q + GW'(1);
        end
        // First edge after GREST release presents pixel (0,0) without advancing
        if (grest_q && !started_q && bus.EN) begin
            started_d = 1'b1;
            load      = 1'b1;
            sof_d     = 1'b1;
            sol_d     = 1'b1;
        end else if (tick) begin
            load = 1'b1;
            if (h_q == H_LAST) begin
                h_d   = '0;
                sol_d = 1'b1;
                if (v_q == V_LAST) begin
                    v_d   = '0;
                    sof_d = 1'b1;
                    frm_d = frm_q + FRM_W'(1);
                end else begin
                    v_d = v_q + VW'(1);
                end
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    always_comb begin
        h_ext  = 32'(h_d);
        v_ext  = 32'(v_d);
        h_in   = (h_ext >= H_START) && (h_ext < H_STOP);
        v_in   = (v_ext >= V_START) && (v_ext < V_STOP);
        hd_d   = hd_q;
        vd_d   = vd_q;
        den_d  = den_q;
        fila_d = fila_q;
        col_d  = col_q;
        if (load) begin
            hd_d   = (h_ext < H_SYNC_C) ? HS_ACT : ~HS_ACT;
            vd_d   = (v_ext < V_SYNC_C) ? VS_ACT : ~VS_ACT;
            den_d  = h_in && v_in;
            fila_d = (h_in && v_in) ? FILA_W'(v_ext - V_START) : '0;
            col_d  = (h_in && v_in) ? COL_W'(h_ext - H_START) : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            grest_q   <= 1'b0;
            gcnt_q    <= '0;
            started_q <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            frm_q     <= '0;
            sof_q     <= 1'b0;
            sol_q     <= 1'b0;
            hd_q      <= ~HS_ACT;
            vd_q      <= ~VS_ACT;
            den_q     <= 1'b0;
            fila_q    <= '0;
            col_q     <= '0;
        end else begin
            grest_q   <= grest_d;
            gcnt_q    <= gcnt_d;
            started_q <= started_d;
            h_q       <= h_d;
            v_q       <= v_d;
            frm_q     <= frm_d;
            sof_q     <= sof_d;
            sol_q     <= sol_d;
            hd_q      <= hd_d;
            vd_q      <= vd_d;
            den_q     <= den_d;
            fila_q    <= fila_d;
            col_q     <= col_d;
        end
    end

    assign bus.NCLK      = nclk;
    assign bus.GREST     = grest_q;
    assign bus.HD        = hd_q;
    assign bus.VD        = vd_q;
    assign bus.DEN       = den_q;
    assign bus.FILA      = fila_q;
    assign bus.COLUMNA   = col_q;
    assign bus.SOF       = sof_q;
    assign bus.SOL       = sol_q;
    assign bus.FRAME_CNT = frm_q;
endmodule

// File: tb/tb_lcd_sync_gen.sv
// Bench for lcd_sync_gen: two instances (GREST_DLY 0 and 5) against a pixel-count reference model.
module tb_lcd_sync_gen;
    localparam int HS = 1, HB = 1, HA = 4, HF = 2;
    localparam int VS = 1, VB = 1, VA = 3, VF = 1;
    localparam int DIV = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;

    typedef struct {
        logic nclk, grest, hd, vd, den, sof, sol;
        int   fila, col, frm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    int dly[2] = '{0, 5};
    int since[2];
    bit grest_m[2];
    bit started_m[2];
    bit pulse_m[2];
    int t_m[2];

    int edge_k      = 0;
    int cyc_since   = 0;
    int last_period = 0;
    int b_sof_edge  = -1;
    int b_gr_edge   = -1;
    bit b_early     = 1'b0;
    int sof_edge;
    bit found;

    always #5 clk = ~clk;

    lcd_sync_gen_if #(.FILA_W(10), .COL_W(11), .FRM_W(8)) bus_a ();
    lcd_sync_gen_if #(.FILA_W(10), .COL_W(11), .FRM_W(8)) bus_b ();
    assign bus_a.EN = en;
    assign bus_b.EN = en;

    lcd_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV), .HS_POL(0), .VS_POL(0), .GREST_DLY(0),
        .FILA_W(10), .COL_W(11), .FRM_W(8)
    ) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));

    lcd_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV), .HS_POL(0), .VS_POL(0), .GREST_DLY(5),
        .FILA_W(10), .COL_W(11), .FRM_W(8)
    ) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: time is counted as advancing edges since the first pixel; h, v, phase and
    // frame follow from plain division of that count.
    task automatic model_edge(input int i);
        bit prev;
        if (rst) begin
            since[i] = 0; grest_m[i] = 0; started_m[i] = 0; t_m[i] = 0; pulse_m[i] = 0;
        end else begin
            prev       = grest_m[i];
            since[i]++;
            grest_m[i] = (since[i] >= dly[i] + 1);
            pulse_m[i] = 0;
            if (en) begin
                if (started_m[i])  t_m[i]++;
                else if (prev) begin started_m[i] = 1; t_m[i] = 0; end
                pulse_m[i] = started_m[i];
            end
        end
    endtask

    function automatic exp_t model_out(input int i);
        exp_t e;
        int p, ph, h, v;
        p  = t_m[i] / DIV;
        ph = t_m[i] % DIV;
        h  = p % HT;
        v  = (p / HT) % VT;
        e.grest = grest_m[i];
        if (!started_m[i]) begin
            e.nclk = 0; e.hd = 1; e.vd = 1; e.den = 0; e.sof = 0; e.sol = 0;
            e.fila = 0; e.col = 0; e.frm = 0;
        end else begin
            e.nclk = (ph >= DIV / 2);
            e.hd   = (h < HS) ? 1'b0 : 1'b1;
            e.vd   = (v < VS) ? 1'b0 : 1'b1;
            e.den  = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
            e.col  = e.den ? h - (HS + HB) : 0;
            e.fila = e.den ? v - (VS + VB) : 0;
            e.sol  = pulse_m[i] && (ph == 0) && (h == 0);
            e.sof  = e.sol && (v == 0);
            e.frm  = (p / (HT * VT)) % 256;
        end
        return e;
    endfunction

    task automatic cmp_dut(input string n, input exp_t o, input exp_t e);
        chk({n, ".NCLK"},  32'(o.nclk),  32'(e.nclk));
        chk({n, ".GREST"}, 32'(o.grest), 32'(e.grest));
        chk({n, ".HD"},    32'(o.hd),    32'(e.hd));
        chk({n, ".VD"},    32'(o.vd),    32'(e.vd));
        chk({n, ".DEN"},   32'(o.den),   32'(e.den));
        chk({n, ".SOF"},   32'(o.sof),   32'(e.sof));
        chk({n, ".SOL"},   32'(o.sol),   32'(e.sol));
        chk({n, ".FILA"},  32'(o.fila),  32'(e.fila));
        chk({n, ".COL"},   32'(o.col),   32'(e.col));
        chk({n, ".FRM"},   32'(o.frm),   32'(e.frm));
    endtask

    task automatic step();
        exp_t oa, ob;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        if (rst) edge_k = 0; else edge_k++;
        @(negedge clk);
        oa.nclk = bus_a.NCLK; oa.grest = bus_a.GREST; oa.hd = bus_a.HD; oa.vd = bus_a.VD;
        oa.den = bus_a.DEN; oa.sof = bus_a.SOF; oa.sol = bus_a.SOL;
        oa.fila = int'(bus_a.FILA); oa.col = int'(bus_a.COLUMNA); oa.frm = int'(bus_a.FRAME_CNT);
        ob.nclk = bus_b.NCLK; ob.grest = bus_b.GREST; ob.hd = bus_b.HD; ob.vd = bus_b.VD;
        ob.den = bus_b.DEN; ob.sof = bus_b.SOF; ob.sol = bus_b.SOL;
        ob.fila = int'(bus_b.FILA); ob.col = int'(bus_b.COLUMNA); ob.frm = int'(bus_b.FRAME_CNT);
        cmp_dut("A", oa, model_out(0));
        cmp_dut("B", ob, model_out(1));
        cyc_since++;
        if (bus_a.SOF) begin last_period = cyc_since; cyc_since = 0; end
        if (!rst) begin
            if (b_sof_edge < 0 && !bus_b.SOF && (!bus_b.HD || !bus_b.VD || bus_b.DEN)) b_early = 1;
            if (b_sof_edge < 0 && bus_b.SOF)   b_sof_edge = edge_k;
            if (b_gr_edge < 0 && bus_b.GREST)  b_gr_edge  = edge_k;
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        repeat (5) step();
        chk("rst_grest", 32'(bus_a.GREST), 32'd0);
        chk("rst_hd",    32'(bus_a.HD),    32'd1);

        // Reset release and first pixel
        rst = 1'b0;
        sof_edge = -1;
        for (int n = 0; n < 20 && sof_edge < 0; n++) begin
            step();
            if (bus_a.SOF) sof_edge = edge_k;
        end
        chk("first_sof_edge", 32'(sof_edge), 32'd2);
        chk("first_nclk_lo",  32'(bus_a.NCLK), 32'd0);
        step();
        chk("first_nclk_hi",  32'(bus_a.NCLK), 32'd1);

        // Frame period with EN held high
        found = 0;
        for (int n = 0; n < 300 && !found; n++) begin step(); found = bus_a.SOF; end
        chk("wait_sof2", 32'(found), 32'd1);
        chk("frame_period", 32'(last_period), 32'd96);
        chk("frame_cnt_1",  32'(bus_a.FRAME_CNT), 32'd1);
        chk("b_grest_edge", 32'(b_gr_edge), 32'd6);
        chk("b_sof_edge",   32'(b_sof_edge), 32'd7);
        chk("b_no_early",   32'(b_early), 32'd0);

        // Freeze for 7 cycles at the first cycle of row 1, column 2
        found = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            step();
            found = bus_a.DEN && bus_a.FILA == 10'd1 && bus_a.COLUMNA == 11'd2 && !bus_a.NCLK;
        end
        chk("wait_r1c2", 32'(found), 32'd1);
        en = 1'b0;
        repeat (7) step();
        en = 1'b1;
        step();
        step();
        chk("resume_col3", 32'(bus_a.COLUMNA), 32'd3);
        found = 0;
        for (int n = 0; n < 300 && !found; n++) begin step(); found = bus_a.SOF; end
        chk("wait_sof_frz", 32'(found), 32'd1);
        chk("frozen_period", 32'(last_period), 32'd103);

        // Mid-frame reset at v=3
        found = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            step();
            found = bus_a.DEN && bus_a.FILA == 10'd1;
        end
        chk("wait_v3", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_grest", 32'(bus_a.GREST), 32'd0);
        chk("mid_rst_frm",   32'(bus_a.FRAME_CNT), 32'd0);
        rst = 1'b0;
        step();
        chk("mid_rel_grest", 32'(bus_a.GREST), 32'd1);
        chk("mid_rel_sof1",  32'(bus_a.SOF), 32'd0);
        step();
        chk("mid_rel_sof2",  32'(bus_a.SOF), 32'd1);
        cyc_since = 0;

        // Random EN drops and occasional resets
        for (int n = 0; n < 3000; n++) begin
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        en  = 1'b1;
        repeat (200) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
